// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the CPU / debug-loader RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DBG  = 2'd2
  } owner_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port RAM between a CPU port and a bursting debug loader.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_last,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  owner_state_t state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       tag_cpu_rd, tag_dbg_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= PORT_DBG;
      beat_cnt   <= 4'd0;
      tag_cpu_rd <= 1'b0;
      tag_dbg_rd <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      tag_cpu_rd <= cpu_gnt && !cpu_we;
      tag_dbg_rd <= dbg_gnt && !dbg_we;
    end
  end

  // Grants and read-valids are forced low during the reset cycle so no RAM access leaks out.
  always_comb begin
    cpu_gnt    = !reset && (state == ST_CPU) && cpu_req;
    dbg_gnt    = !reset && (state == ST_DBG) && dbg_req;
    cpu_stall  = cpu_req && !cpu_gnt;
    cpu_rvalid = !reset && tag_cpu_rd;
    dbg_rvalid = !reset && tag_dbg_rd;
    cpu_rdata  = ram_rdata;
    dbg_rdata  = ram_rdata;
    ram_en     = cpu_gnt || dbg_gnt;
    ram_we     = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    ram_addr   = dbg_gnt ? dbg_addr : cpu_addr;
    ram_wdata  = dbg_gnt ? dbg_wdata : cpu_wdata;
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = 4'd0;
    last_owner_nxt = last_owner;
    if (cpu_gnt) last_owner_nxt = PORT_CPU;
    if (dbg_gnt) last_owner_nxt = PORT_DBG;
    case (state)
      ST_IDLE: begin
        if (cpu_req && dbg_req) state_nxt = (last_owner == PORT_CPU) ? ST_DBG : ST_CPU;
        else if (cpu_req)       state_nxt = ST_CPU;
        else if (dbg_req)       state_nxt = ST_DBG;
        else                    state_nxt = ST_IDLE;
      end
      ST_CPU: begin
        if (dbg_req)      state_nxt = ST_DBG;
        else if (cpu_req) state_nxt = ST_CPU;
        else              state_nxt = ST_IDLE;
      end
      ST_DBG: begin
        // A waiting CPU always takes the slot once a burst ends; otherwise a new burst restarts the count.
        if (dbg_req && !dbg_last && (beat_cnt < BURST_LAST)) begin
          state_nxt    = ST_DBG;
          beat_cnt_nxt = beat_cnt + 4'd1;
        end else if (cpu_req) state_nxt = ST_CPU;
        else if (dbg_req)     state_nxt = ST_DBG;
        else                  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random-mix checks for ram_port_arbiter against a behavioural RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_last, dbg_gnt, dbg_rvalid;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [256];
  logic [31:0] mem_ref [256];
  logic        mem_clear;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_last(dbg_last), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {16'hA5C3, 8'h00, a};
  endfunction

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_last = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); end
    n_cmp++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); end
    n_cmp++; if (ram_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ram_en: got %b want 0", ram_en); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_rvalid: got %b%b want 00", cpu_rvalid, dbg_rvalid);
    end
    next_cycle();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    n_cmp++; if (ram_en !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_rst_quiet: got en=%b stall=%b want 0 0", ram_en, cpu_stall);
    end
    next_cycle();
  endtask

  task automatic test_cpu_read();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL cr_stall_c1: got %b want 1", cpu_stall); end
    n_cmp++; if (cpu_gnt !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cr_gnt_c1: got gnt=%b en=%b want 0 0", cpu_gnt, ram_en);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cr_gnt_c2: got gnt=%b en=%b we=%b want 1 1 0", cpu_gnt, ram_en, ram_we);
    end
    n_cmp++; if (ram_addr !== 8'h10) begin n_fail++; $display("[TB] FAIL cr_addr: got %h want 10", ram_addr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cr_stall_c2: got %b want 0", cpu_stall); end
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cr_rvalid: got cpu=%b dbg=%b want 1 0", cpu_rvalid, dbg_rvalid);
    end
    n_cmp++; if (cpu_rdata !== init_val(8'h10)) begin
      n_fail++; $display("[TB] FAIL cr_rdata: got %h want %h", cpu_rdata, init_val(8'h10));
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL cr_rvalid_once: got %b want 0", cpu_rvalid); end
    next_cycle();
  endtask

  task automatic test_tie();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h30; dbg_last = 1;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      n_fail++; $display("[TB] FAIL tie_c1_gnt: got %b%b want 00", cpu_gnt, dbg_gnt);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      n_fail++; $display("[TB] FAIL tie_cpu_first: got cpu=%b dbg=%b want 1 0", cpu_gnt, dbg_gnt);
    end
    n_cmp++; if (ram_addr !== 8'h20) begin n_fail++; $display("[TB] FAIL tie_addr_cpu: got %h want 20", ram_addr); end
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    n_cmp++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_fail++; $display("[TB] FAIL tie_dbg_next: got cpu=%b dbg=%b want 0 1", cpu_gnt, dbg_gnt);
    end
    n_cmp++; if (ram_addr !== 8'h30) begin n_fail++; $display("[TB] FAIL tie_addr_dbg: got %h want 30", ram_addr); end
    n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== init_val(8'h20)) begin
      n_fail++; $display("[TB] FAIL tie_cpu_rvalid: got %b/%h want 1/%h", cpu_rvalid, cpu_rdata, init_val(8'h20));
    end
    next_cycle();
    dbg_req = 0; dbg_last = 0;
    @(negedge clk);
    n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== init_val(8'h30) || cpu_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL tie_dbg_rvalid: got %b/%h cpu=%b want 1/%h cpu=0", dbg_rvalid, dbg_rdata, cpu_rvalid, init_val(8'h30));
    end
    next_cycle();
  endtask

  // 6-beat debug write burst; the CPU asks during beat 2 and is served after beat 4.
  task automatic test_burst_preempt();
    logic [8:0] t_cpu  = 9'b000111100;
    logic [8:0] exp_dg = 9'b011011110;
    logic [8:0] exp_cg = 9'b000100000;
    logic [8:0] exp_st = 9'b000011100;
    int b = 0;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      cpu_req = t_cpu[c]; cpu_we = 1; cpu_addr = 8'h80; cpu_wdata = 32'hC0DE_0080;
      dbg_req = (b < 6); dbg_we = 1; dbg_addr = 8'(8'h40 + b);
      dbg_wdata = 32'hD000_0000 + 32'(b); dbg_last = (b == 5);
      @(negedge clk);
      n_cmp++; if (dbg_gnt !== exp_dg[c] || cpu_gnt !== exp_cg[c]) begin
        n_fail++; $display("[TB] FAIL bp_gnt c%0d: got cpu=%b dbg=%b want %b %b", c, cpu_gnt, dbg_gnt, exp_cg[c], exp_dg[c]);
      end
      n_cmp++; if (cpu_stall !== exp_st[c]) begin
        n_fail++; $display("[TB] FAIL bp_stall c%0d: got %b want %b", c, cpu_stall, exp_st[c]);
      end
      n_cmp++; if (ram_en !== (exp_dg[c] | exp_cg[c]) || cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL bp_en c%0d: got en=%b rv=%b%b want en=%b rv=00", c, ram_en, cpu_rvalid, dbg_rvalid, exp_dg[c] | exp_cg[c]);
      end
      if (exp_dg[c]) b++;
      next_cycle();
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (mem[8'h40 + k] !== 32'hD000_0000 + 32'(k)) begin
        n_fail++; $display("[TB] FAIL bp_mem %0d: got %h want %h", k, mem[8'h40 + k], 32'hD000_0000 + 32'(k));
      end
    end
    n_cmp++; if (mem[8'h80] !== 32'hC0DE_0080) begin
      n_fail++; $display("[TB] FAIL bp_mem_cpu: got %h want c0de0080", mem[8'h80]);
    end
  endtask

  // Read burst ended by dbg_last after 2 beats, then a full 4-beat burst to show the counter restarted.
  task automatic test_dbg_last();
    logic [9:0] t_cpu  = 10'b0111111100;
    logic [9:0] exp_dg = 10'b0011110110;
    logic [9:0] exp_cg = 10'b0100001000;
    logic [9:0] exp_st = 10'b0011110100;
    logic [9:0] exp_dv = 10'b0111101100;
    logic [9:0] exp_cv = 10'b1000010000;
    logic [7:0] last_d = 0, last_c = 0;
    int b = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cpu_req = t_cpu[c]; cpu_we = 0; cpu_addr = (c <= 3) ? 8'h60 : 8'h61;
      dbg_req = (b < 6); dbg_we = 0; dbg_addr = 8'(8'h50 + b); dbg_last = (b == 1);
      @(negedge clk);
      n_cmp++; if (dbg_gnt !== exp_dg[c] || cpu_gnt !== exp_cg[c]) begin
        n_fail++; $display("[TB] FAIL dl_gnt c%0d: got cpu=%b dbg=%b want %b %b", c, cpu_gnt, dbg_gnt, exp_cg[c], exp_dg[c]);
      end
      n_cmp++; if (cpu_stall !== exp_st[c]) begin
        n_fail++; $display("[TB] FAIL dl_stall c%0d: got %b want %b", c, cpu_stall, exp_st[c]);
      end
      n_cmp++; if (dbg_rvalid !== exp_dv[c] || cpu_rvalid !== exp_cv[c]) begin
        n_fail++; $display("[TB] FAIL dl_rvalid c%0d: got cpu=%b dbg=%b want %b %b", c, cpu_rvalid, dbg_rvalid, exp_cv[c], exp_dv[c]);
      end
      if (exp_dv[c]) begin
        n_cmp++; if (dbg_rdata !== init_val(last_d)) begin
          n_fail++; $display("[TB] FAIL dl_drdata c%0d: got %h want %h", c, dbg_rdata, init_val(last_d));
        end
      end
      if (exp_cv[c]) begin
        n_cmp++; if (cpu_rdata !== init_val(last_c)) begin
          n_fail++; $display("[TB] FAIL dl_crdata c%0d: got %h want %h", c, cpu_rdata, init_val(last_c));
        end
      end
      if (exp_dg[c]) begin last_d = dbg_addr; b++; end
      if (exp_cg[c]) last_c = cpu_addr;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_dbg_drop();
    apply_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h70; dbg_wdata = 32'h7777_0070;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL dd_first_beat: got %b want 1", dbg_gnt); end
    next_cycle();
    dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    @(negedge clk);
    n_cmp++; if (dbg_gnt !== 1'b0 || cpu_gnt !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dd_no_beat: got cpu=%b dbg=%b en=%b want 0 0 0", cpu_gnt, dbg_gnt, ram_en);
    end
    n_cmp++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL dd_wr_rvalid: got %b want 0", dbg_rvalid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || ram_addr !== 8'h12) begin
      n_fail++; $display("[TB] FAIL dd_cpu_next: got gnt=%b addr=%h want 1 12", cpu_gnt, ram_addr);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h11;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL ri_gnt: got %b want 1", cpu_gnt); end
    next_cycle();
    reset = 1; dbg_req = 1;
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ri_rst_cycle: got rv=%b gnt=%b%b en=%b we=%b want all 0", cpu_rvalid, cpu_gnt, dbg_gnt, ram_en, ram_we);
    end
    next_cycle();
    reset = 0; dbg_req = 0;
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ri_after: got rv=%b gnt=%b stall=%b want 0 0 1", cpu_rvalid, cpu_gnt, cpu_stall);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || ram_addr !== 8'h11) begin
      n_fail++; $display("[TB] FAIL ri_regrant: got gnt=%b addr=%h want 1 11", cpu_gnt, ram_addr);
    end
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== init_val(8'h11)) begin
      n_fail++; $display("[TB] FAIL ri_rvalid: got %b/%h want 1/%h", cpu_rvalid, cpu_rdata, init_val(8'h11));
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic        c_taken = 0, d_taken = 0, pend_c = 0, pend_d = 0;
    logic [31:0] pend_cd = 0, pend_dd = 0;
    int          run = 0, max_run = 0;
    apply_reset();
    for (int i = 0; i < 256; i++) mem_ref[i] = mem[i];
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (c_taken) begin cpu_req = 0; c_taken = 0; end
      if (d_taken) begin dbg_req = 0; d_taken = 0; end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'hC0 | 8'($urandom_range(0, 15)); cpu_wdata = 32'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 3) != 0) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1)); dbg_last = ($urandom_range(0, 3) == 0);
        dbg_addr = 8'hC0 | 8'($urandom_range(0, 15)); dbg_wdata = 32'($urandom);
      end
      @(negedge clk);
      n_cmp++; if (cpu_gnt && dbg_gnt) begin n_fail++; $display("[TB] FAIL rnd_both_gnt cyc%0d: got 11 want not both", cyc); end
      n_cmp++; if (cpu_rvalid !== pend_c || dbg_rvalid !== pend_d) begin
        n_fail++; $display("[TB] FAIL rnd_rvalid cyc%0d: got %b%b want %b%b", cyc, cpu_rvalid, dbg_rvalid, pend_c, pend_d);
      end
      if (pend_c) begin
        n_cmp++; if (cpu_rdata !== pend_cd) begin n_fail++; $display("[TB] FAIL rnd_crdata cyc%0d: got %h want %h", cyc, cpu_rdata, pend_cd); end
      end
      if (pend_d) begin
        n_cmp++; if (dbg_rdata !== pend_dd) begin n_fail++; $display("[TB] FAIL rnd_drdata cyc%0d: got %h want %h", cyc, dbg_rdata, pend_dd); end
      end
      n_cmp++; if (ram_en !== (cpu_gnt | dbg_gnt) || cpu_stall !== (cpu_req && !cpu_gnt)) begin
        n_fail++; $display("[TB] FAIL rnd_en_stall cyc%0d: got en=%b stall=%b", cyc, ram_en, cpu_stall);
      end
      pend_c = 0; pend_d = 0;
      if (cpu_gnt) begin
        n_cmp++; if (!cpu_req || ram_we !== cpu_we || ram_addr !== cpu_addr || (cpu_we && ram_wdata !== cpu_wdata)) begin
          n_fail++; $display("[TB] FAIL rnd_cpu_access cyc%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", cyc, ram_we, ram_addr, ram_wdata, cpu_we, cpu_addr, cpu_wdata);
        end
        if (cpu_we) mem_ref[cpu_addr] = cpu_wdata;
        else begin pend_c = 1; pend_cd = mem_ref[cpu_addr]; end
        c_taken = 1;
      end
      if (dbg_gnt) begin
        n_cmp++; if (!dbg_req || ram_we !== dbg_we || ram_addr !== dbg_addr || (dbg_we && ram_wdata !== dbg_wdata)) begin
          n_fail++; $display("[TB] FAIL rnd_dbg_access cyc%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", cyc, ram_we, ram_addr, ram_wdata, dbg_we, dbg_addr, dbg_wdata);
        end
        if (dbg_we) mem_ref[dbg_addr] = dbg_wdata;
        else begin pend_d = 1; pend_dd = mem_ref[dbg_addr]; end
        d_taken = 1;
      end
      if (cpu_stall) run++; else run = 0;
      if (run > max_run) max_run = run;
      next_cycle();
    end
    n_cmp++; if (max_run > 5) begin n_fail++; $display("[TB] FAIL rnd_cpu_wait: got %0d want <= 5", max_run); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    mem_clear = 1;
    next_cycle();
    mem_clear = 0;
    next_cycle();
    test_reset();
    test_cpu_read();
    test_tie();
    test_burst_preempt();
    test_dbg_last();
    test_dbg_drop();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter MAX_BURST, default 4, maximum debug beats per grant (range 1-15).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU access request / write-not-read.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU address / write data.
REQ-008 cpu_gnt / cpu_stall  output  1 / 1  CPU access issued this cycle / CPU must hold its pipeline.
REQ-009 cpu_rvalid / cpu_rdata  output  1 / DATA_W  CPU read data valid / read data.
REQ-010 dbg_req / dbg_we / dbg_last  input  1 / 1 / 1  debug-loader request / write-not-read / final beat of burst.
REQ-011 dbg_addr / dbg_wdata  input  ADDR_W / DATA_W  debug address / write data.
REQ-012 dbg_gnt / dbg_rvalid / dbg_rdata  output  1 / 1 / DATA_W  debug beat issued / read valid / read data.
REQ-013 ram_en / ram_we  output  1 / 1  RAM enable / write enable.
REQ-014 ram_addr / ram_wdata  output  ADDR_W / DATA_W  RAM address / write data.
REQ-015 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-016 Owner FSM states SHALL be IDLE, CPU, DBG; registered.
REQ-017 cpu_gnt SHALL equal (state==CPU)&&cpu_req; dbg_gnt SHALL equal (state==DBG)&&dbg_req; never both high.
REQ-018 On a grant, ram_en=1 and ram_we/ram_addr/ram_wdata SHALL be the granted port's inputs in the same cycle; otherwise ram_en=0, ram_we=0.
REQ-019 cpu_stall SHALL equal cpu_req&&!cpu_gnt.
REQ-020 IDLE: both req -> port not equal to last_owner; cpu_req only -> CPU; dbg_req only -> DBG; none -> IDLE.
REQ-021 CPU: one beat per visit; next = DBG if dbg_req, else CPU if cpu_req, else IDLE.
REQ-022 DBG: beat_cnt counts issued beats; stay DBG while dbg_req && !dbg_last && beat_cnt<MAX_BURST-1; on burst end next = CPU if cpu_req, else DBG (beat_cnt cleared) if dbg_req, else IDLE.
REQ-023 dbg_req deasserting in DBG SHALL end the burst without a beat.
REQ-024 last_owner SHALL update to the port granted on every issued beat.
REQ-025 Request-to-grant latency from IDLE SHALL be exactly 1 cycle; max CPU wait SHALL be MAX_BURST beats plus 1 cycle.
REQ-026 A registered tag SHALL record issuer and read flag; x_rvalid SHALL pulse exactly 1 cycle after a granted read from port x; never after writes.
REQ-027 cpu_rdata and dbg_rdata SHALL both carry ram_rdata; validity is conveyed only by rvalid.
REQ-028 Back-to-back reads SHALL be supported; rvalid of beat N coincides with grant of beat N+1.

Reset
REQ-029 On reset: state=IDLE, last_owner=DBG (CPU wins first tie), beat_cnt=0, read tag cleared; all grants, rvalids, ram_en, ram_we SHALL be 0 in the reset cycle.
REQ-030 Reset mid-burst or with read in flight SHALL suppress the pending rvalid and abandon the burst; no RAM access in the reset cycle.

Structure
REQ-031 A shared package SHALL hold the owner-state enum, the port-ID constants (PORT_CPU=0, PORT_DBG=1) and default ADDR_W/DATA_W.
REQ-032 Implementation SHALL be a single module; no sub-module required.

Verification
REQ-033 CPU read addr 0x10 alone from IDLE -> cpu_gnt in cycle 2, ram_addr=0x10, cpu_rvalid in cycle 3 with RAM content; cpu_stall high in cycle 1 only.
REQ-034 Simultaneous cpu_req/dbg_req after reset -> CPU granted first, DBG next cycle.
REQ-035 dbg write burst of 6 beats, MAX_BURST=4, cpu_req raised on beat 2 -> 4 dbg beats, 1 CPU beat, then remaining 2 dbg beats; cpu_stall high exactly during the wait.
REQ-036 dbg burst with dbg_last on beat 2 -> FSM leaves DBG after 2 beats; beat_cnt back to 0.
REQ-037 Reset asserted the cycle after a CPU read grant -> no cpu_rvalid; state IDLE; next request granted normally.
REQ-038 Random mixed traffic checker: never both grants high; every read returns exactly one rvalid to its issuer; write data observed at RAM matches requester.
